matrix_mult_ctrl: RTL and testbench
===================================

# matrix_mult_ctrl

Sequencer for the lineq_solve matrix multiply path. It drives a single shared 32-bit multiply-accumulate unit and the element memories holding matrix 1 (m×n), matrix 2 (n×p) and the result (m×p). It walks every output element, issues the operand read addresses, steers MAC clear/enable, and issues result writebacks. Arithmetic and storage live in the datapath; this block only owns ordering, counting and handshake.

## Interface
- DIM_W, 8, width of each dimension input; legal dimension range 1..128
- ADDR_W, 14, element address width; row-major, 128×128 elements max
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- mult  in  1  start request; sampled only in IDLE
- m1_dim  in  DIM_W  rows of matrix 1 (m)
- n1_dim  in  DIM_W  columns of matrix 1 = rows of matrix 2 (n)
- n2_dim  in  DIM_W  columns of matrix 2 (p)
- stall  in  1  datapath not ready; freezes the controller
- a_addr  out  ADDR_W  matrix 1 read address, i*n + k
- b_addr  out  ADDR_W  matrix 2 read address, k*p + j
- addr_vld  out  1  a_addr/b_addr valid this cycle
- mac_clr  out  1  with mac_en: load product, discard accumulator (k = 0 term)
- mac_en  out  1  accumulate product of data read the previous cycle
- c_addr  out  ADDR_W  result write address, i*p + j
- c_we  out  1  write MAC result to c_addr
- busy  out  1  high from RUN entry until DONE exit
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when dimensions are illegal

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when mult = 1, latch m, n, p.
  - If any latched dimension is 0 or >128, go to DONE with err set. No addr_vld, mac_en or c_we is issued.
  - Otherwise go to RUN.
  - mult in any other state is ignored; there is no queueing.
- RUN: one address pair per unstalled cycle. Loop order is k innermost, then j, then i, i.e. i = 0..m-1, j = 0..p-1, k = 0..n-1.
- Addresses are generated incrementally, with no multiplier:
  - a_addr: row base += n on each i step; a_addr = row base + k.
  - b_addr: += p on each k step; reloads to j at k = 0.
  - c_addr: +1 per completed output element, starting at 0.
- The last address pair (i = m-1, j = p-1, k = n-1) moves the FSM to DRAIN.
- Two-stage tag pipeline, fixed to match the datapath's 1-cycle read latency and 1-cycle MAC register:
  - Stage 1 (cycle after addr_vld): mac_en = 1; mac_clr = (k == 0).
  - Stage 2 (cycle after that): c_we = 1 only if the stage-1 tag had k == n-1. c_addr is carried with the tag.
- DRAIN: no new addresses. Leave for DONE once both pipeline stages are empty.
- DONE: assert done (and err if set) for one cycle, then go to IDLE.
- stall = 1 holds the FSM, counters and both tag stages. While stalled, addr_vld, mac_en and c_we are forced to 0 and all addresses hold their values. The datapath must hold its read data across a stall.
- Reset low at any time, including mid-RUN: immediate return to IDLE. Outputs are cleared; partially written results are abandoned.

## Timing
- Reset values: all outputs 0; state IDLE.
- With mult sampled high at edge E0 and no stalls:
  - addr_vld rises in cycle 1 (after E0) and stays high for m·n·p cycles.
  - First mac_en is in cycle 2.
  - First c_we is in cycle n+2. Thereafter one c_we every n cycles, m·p in total.
  - Last c_we is in cycle m·n·p+2.
  - done is in cycle m·n·p+3.
- Each stalled cycle adds exactly one cycle to every subsequent event.
- Illegal dimensions: done and err in cycle 1; busy never asserts.
- busy is high from cycle 1 through the cycle before done. busy is low in the done cycle.
- The next mult is accepted at the first edge after done.
- 1×1×1 minimum: addr_vld in cycle 1; mac_en and mac_clr in cycle 2; c_we with c_addr 0 in cycle 3; done in cycle 4.

## Test plan
- m=2, n=2, p=2, no stall -> a_addr sequence 0,1,0,1,2,3,2,3; b_addr sequence 0,2,1,3,0,2,1,3; mac_clr on every other mac_en; c_we at cycles 4,6,8,10 with c_addr 0,1,2,3; done at cycle 11.
- m=3, n=2, p=1 with a behavioural memory and MAC, A=[1 2;3 4;5 6], B=[1;1] -> stored results 3,7,11; c_we count 3; done at cycle 9.
- Same 2×2×2 run with stall high for 3 cycles starting at cycle 3 -> address, mac and c_we sequences unchanged but shifted by 3; no mac_en or c_we during the stall; done at cycle 14.
- m1_dim=0 (then separately n2_dim=129) -> done and err together in cycle 1; zero addr_vld, mac_en and c_we.
- Reset driven low in cycle 5 of a 4×4×4 run -> all outputs 0 within the reset cycle; state IDLE; a new mult after reset release runs the full sequence from c_addr 0.
- mult held high throughout a run -> the second start is accepted only at the edge after done; there is no overlap of busy periods.

Source files
------------

// File: rtl/matrix_mult_ctrl_if.sv
// rtl/matrix_mult_ctrl_if.sv - start/dimension/stall inputs and MAC/memory sequencing outputs of matrix_mult_ctrl
interface matrix_mult_ctrl_if #(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 14
);
    logic              mult;
    logic [DIM_W-1:0]  m1_dim;
    logic [DIM_W-1:0]  n1_dim;
    logic [DIM_W-1:0]  n2_dim;
    logic              stall;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              addr_vld;
    logic              mac_clr;
    logic              mac_en;
    logic [ADDR_W-1:0] c_addr;
    logic              c_we;
    logic              busy;
    logic              done;
    logic              err;

    // Host / datapath side: issues the start request and stall, consumes the sequencing outputs
    modport master (
        output mult, m1_dim, n1_dim, n2_dim, stall,
        input  a_addr, b_addr, addr_vld, mac_clr, mac_en, c_addr, c_we, busy, done, err
    );

    // Controller side
    modport slave (
        input  mult, m1_dim, n1_dim, n2_dim, stall,
        output a_addr, b_addr, addr_vld, mac_clr, mac_en, c_addr, c_we, busy, done, err
    );
endinterface

// File: rtl/matrix_mult_ctrl.sv
// rtl/matrix_mult_ctrl.sv - sequencer for the shared MAC matrix multiply path (addresses, MAC control, writeback)
module matrix_mult_ctrl #(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic                clk,
    input  logic                reset,
    matrix_mult_ctrl_if.slave   bus
);

    localparam int MAX_DIM = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;

    // Latched dimensions: last index of each loop plus the address strides
    logic [DIM_W-1:0]  m_last;
    logic [DIM_W-1:0]  n_last;
    logic [DIM_W-1:0]  p_last;
    logic [ADDR_W-1:0] n_step;
    logic [ADDR_W-1:0] p_step;

    // Loop counters and incrementally generated addresses
    logic [DIM_W-1:0]  i_cnt;
    logic [DIM_W-1:0]  j_cnt;
    logic [DIM_W-1:0]  k_cnt;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    logic [ADDR_W-1:0] c_cnt;

    // Tag pipeline: v0 = address stage, v1 = MAC stage, v2 = writeback stage
    logic              v0;
    logic              v1;
    logic              v2;
    logic              t1_clr;
    logic              t1_last;
    logic [ADDR_W-1:0] t1_c;
    logic [ADDR_W-1:0] c_q;

    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              dims_ok;
    logic              start;
    logic              last_pair;
    logic              k_wrap;

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAX_DIM));
    endfunction

    assign dims_ok   = dim_ok(bus.m1_dim) && dim_ok(bus.n1_dim) && dim_ok(bus.n2_dim);
    // A start is accepted in IDLE or on the edge that ends the done pulse
    assign start     = bus.mult && ((state == IDLE) || (state == DONE));
    assign k_wrap    = (k_cnt == n_last);
    assign last_pair = k_wrap && (j_cnt == p_last) && (i_cnt == m_last);

    // Sequencer FSM, loop counters, address generation and tag pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            m_last   <= '0;
            n_last   <= '0;
            p_last   <= '0;
            n_step   <= '0;
            p_step   <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            row_base <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_cnt    <= '0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            t1_clr   <= 1'b0;
            t1_last  <= 1'b0;
            t1_c     <= '0;
            c_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // The tag stages move only on unstalled cycles; outside RUN/DRAIN they are empty
            if (!bus.stall) begin
                v1      <= v0;
                t1_clr  <= (k_cnt == '0);
                t1_last <= k_wrap;
                t1_c    <= c_cnt;
                v2      <= v1 && t1_last;
                if (v1 && t1_last) begin
                    c_q <= t1_c;
                end
            end

            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    state  <= IDLE;
                    if (start) begin
                        m_last   <= bus.m1_dim - DIM_W'(1);
                        n_last   <= bus.n1_dim - DIM_W'(1);
                        p_last   <= bus.n2_dim - DIM_W'(1);
                        n_step   <= ADDR_W'(bus.n1_dim);
                        p_step   <= ADDR_W'(bus.n2_dim);
                        i_cnt    <= '0;
                        j_cnt    <= '0;
                        k_cnt    <= '0;
                        row_base <= '0;
                        a_q      <= '0;
                        b_q      <= '0;
                        c_cnt    <= '0;
                        if (dims_ok) begin
                            state  <= RUN;
                            v0     <= 1'b1;
                            busy_q <= 1'b1;
                        end else begin
                            // Illegal shape: report immediately, never touch the datapath
                            state  <= DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (!bus.stall) begin
                        if (last_pair) begin
                            v0    <= 1'b0;
                            state <= DRAIN;
                        end else if (!k_wrap) begin
                            k_cnt <= k_cnt + DIM_W'(1);
                            a_q   <= a_q + ADDR_W'(1);
                            b_q   <= b_q + p_step;
                        end else begin
                            // Output element complete: restart k, move to next column or row
                            k_cnt <= '0;
                            c_cnt <= c_cnt + ADDR_W'(1);
                            if (j_cnt != p_last) begin
                                j_cnt <= j_cnt + DIM_W'(1);
                                a_q   <= row_base;
                                b_q   <= ADDR_W'(j_cnt) + ADDR_W'(1);
                            end else begin
                                j_cnt    <= '0;
                                i_cnt    <= i_cnt + DIM_W'(1);
                                row_base <= row_base + n_step;
                                a_q      <= row_base + n_step;
                                b_q      <= '0;
                            end
                        end
                    end
                end

                DRAIN: begin
                    // With v0 empty, an empty MAC stage means the writeback stage empties this edge
                    if (!bus.stall && !v1) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall suppresses every datapath strobe while the registered addresses hold
    assign bus.a_addr   = a_q;
    assign bus.b_addr   = b_q;
    assign bus.c_addr   = c_q;
    assign bus.addr_vld = v0 && !bus.stall;
    assign bus.mac_en   = v1 && !bus.stall;
    assign bus.mac_clr  = v1 && t1_clr && !bus.stall;
    assign bus.c_we     = v2 && !bus.stall;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// tb/tb_matrix_mult_ctrl.sv - scoreboard bench for matrix_mult_ctrl with memory/MAC reference model
module tb_matrix_mult_ctrl;

    localparam int DIM_W  = 8;
    localparam int ADDR_W = 14;

    logic clk_tb = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;
    logic exp_busy = 1'b0;
    int   run_id = 0;

    matrix_mult_ctrl_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

    matrix_mult_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk_tb),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_tb = ~clk_tb;

    always @(posedge clk_tb) cyc <= cyc + 1;

    typedef struct { int a; int b; int cyc; } ab_t;
    typedef struct { bit clr; int cyc; }      mac_t;
    typedef struct { int addr; int cyc; }     wr_t;
    typedef struct { bit err; int cyc; }      done_t;

    ab_t   q_ab[$];
    mac_t  q_mac[$];
    wr_t   q_wr[$];
    done_t q_done[$];

    logic [31:0] amem [0:16383];
    logic [31:0] bmem [0:16383];
    logic [31:0] cmem [0:16383];
    int          cmem_run [0:16383];
    logic [31:0] rd_a, rd_b, acc;

    // Datapath model: 1-cycle memory read, MAC register, result store
    always @(posedge clk_tb) begin
        if (bus.addr_vld) begin
            rd_a <= amem[bus.a_addr];
            rd_b <= bmem[bus.b_addr];
        end
        if (bus.mac_en) acc <= (bus.mac_clr ? 32'd0 : acc) + rd_a * rd_b;
        if (bus.c_we) begin
            cmem[bus.c_addr]     <= acc;
            cmem_run[bus.c_addr] <= run_id;
        end
    end

    // Monitor: pops expected events whenever the DUT presents one
    initial begin : monitor
        ab_t   e_ab;
        mac_t  e_mac;
        wr_t   e_wr;
        done_t e_dn;
        forever begin
            @(negedge clk_tb);
            if (reset === 1'b1) begin
                tests++;
                if (bus.busy !== exp_busy) begin
                    fails++;
                    $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, exp_busy);
                end
                if (bus.addr_vld) begin
                    tests++;
                    if (q_ab.size() == 0) begin
                        fails++;
                        $display("FAIL addr_vld unexpected cyc=%0d a=%0d b=%0d", cyc, bus.a_addr, bus.b_addr);
                    end else begin
                        e_ab = q_ab.pop_front();
                        if (int'(bus.a_addr) != e_ab.a || int'(bus.b_addr) != e_ab.b || cyc != e_ab.cyc) begin
                            fails++;
                            $display("FAIL addr got a=%0d b=%0d cyc=%0d want a=%0d b=%0d cyc=%0d",
                                     bus.a_addr, bus.b_addr, cyc, e_ab.a, e_ab.b, e_ab.cyc);
                        end
                    end
                end
                if (bus.mac_en) begin
                    tests++;
                    if (q_mac.size() == 0) begin
                        fails++;
                        $display("FAIL mac_en unexpected cyc=%0d", cyc);
                    end else begin
                        e_mac = q_mac.pop_front();
                        if (bus.mac_clr !== e_mac.clr || cyc != e_mac.cyc) begin
                            fails++;
                            $display("FAIL mac got clr=%b cyc=%0d want clr=%b cyc=%0d",
                                     bus.mac_clr, cyc, e_mac.clr, e_mac.cyc);
                        end
                    end
                end
                if (bus.c_we) begin
                    tests++;
                    if (q_wr.size() == 0) begin
                        fails++;
                        $display("FAIL c_we unexpected cyc=%0d c_addr=%0d", cyc, bus.c_addr);
                    end else begin
                        e_wr = q_wr.pop_front();
                        if (int'(bus.c_addr) != e_wr.addr || cyc != e_wr.cyc) begin
                            fails++;
                            $display("FAIL c_we got c_addr=%0d cyc=%0d want c_addr=%0d cyc=%0d",
                                     bus.c_addr, cyc, e_wr.addr, e_wr.cyc);
                        end
                    end
                end
                if (bus.done) begin
                    tests++;
                    if (q_done.size() == 0) begin
                        fails++;
                        $display("FAIL done unexpected cyc=%0d", cyc);
                    end else begin
                        e_dn = q_done.pop_front();
                        if (bus.err !== e_dn.err || cyc != e_dn.cyc) begin
                            fails++;
                            $display("FAIL done got err=%b cyc=%0d want err=%b cyc=%0d",
                                     bus.err, cyc, e_dn.err, e_dn.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        logic [3*ADDR_W+6:0] got;
        got = {bus.a_addr, bus.b_addr, bus.c_addr, bus.addr_vld, bus.mac_en,
               bus.mac_clr, bus.c_we, bus.busy, bus.done, bus.err};
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL %s outputs got=%h want=0", tag, got);
        end
    endtask

    task automatic check_empty(input string tag, input int sz);
        tests++;
        if (sz != 0) begin
            fails++;
            $display("FAIL %s leftover got=%0d want=0", tag, sz);
        end
    endtask

    // One multiply: smode 0 = no stall, 1 = stall cycles 3..5, 2 = random stall
    task automatic run(input int m, input int n, input int p, input int smode,
                       input bit hold, input bit fixed, input int abort_at);
        bit          legal;
        int          nn, u, c;
        bit          s;
        int          pa[$];
        int          pb[$];
        bit          pc[$];
        logic [31:0] expc[$];
        logic [31:0] sum;

        legal = (m >= 1 && m <= 128 && n >= 1 && n <= 128 && p >= 1 && p <= 128);
        run_id++;
        if (legal) begin
            for (int i = 0; i < m; i++)
                for (int k = 0; k < n; k++)
                    amem[i*n+k] = fixed ? 32'(i*n+k+1) : 32'($urandom_range(0, 1000));
            for (int k = 0; k < n; k++)
                for (int j = 0; j < p; j++)
                    bmem[k*p+j] = fixed ? 32'd1 : 32'($urandom_range(0, 1000));
            for (int i = 0; i < m; i++)
                for (int j = 0; j < p; j++) begin
                    sum = 0;
                    for (int k = 0; k < n; k++) sum = sum + amem[i*n+k] * bmem[k*p+j];
                    expc.push_back(sum);
                    for (int k = 0; k < n; k++) begin
                        pa.push_back(i*n+k);
                        pb.push_back(k*p+j);
                        pc.push_back(k == 0);
                    end
                end
        end

        bus.m1_dim = DIM_W'(m);
        bus.n1_dim = DIM_W'(n);
        bus.n2_dim = DIM_W'(p);
        bus.mult   = 1'b1;
        @(posedge clk_tb); #1;
        if (!hold) bus.mult = 1'b0;
        nn = legal ? m*n*p : 0;

        if (legal) begin
            exp_busy = 1'b1;
            u = 0;
            c = 1;
            while (u < nn + 2) begin
                if (c == abort_at) begin
                    reset = 1'b0;
                    #1;
                    check_idle_outputs("reset_mid_run");
                    q_ab.delete();
                    q_mac.delete();
                    q_wr.delete();
                    exp_busy  = 1'b0;
                    bus.stall = 1'b0;
                    bus.mult  = 1'b0;
                    return;
                end
                case (smode)
                    1:       s = (c >= 3 && c <= 5);
                    2:       s = ($urandom_range(0, 3) == 0);
                    default: s = 1'b0;
                endcase
                bus.stall = s;
                if (!s) begin
                    u++;
                    if (u <= nn)                  q_ab.push_back('{pa[u-1], pb[u-1], cyc});
                    if (u >= 2 && u - 1 <= nn)    q_mac.push_back('{pc[u-2], cyc});
                    if (u >= 3 && (u-2) % n == 0) q_wr.push_back('{(u-2)/n - 1, cyc});
                end
                @(posedge clk_tb); #1;
                c++;
            end
            bus.stall = 1'b0;
            exp_busy  = 1'b0;
        end
        q_done.push_back('{!legal, cyc});

        @(negedge clk_tb); #1;
        check_empty("done_missing", q_done.size());
        q_done.delete();
        check_empty("addr_pairs", q_ab.size());
        check_empty("mac_events", q_mac.size());
        check_empty("writes", q_wr.size());
        q_ab.delete();
        q_mac.delete();
        q_wr.delete();
        if (legal) begin
            for (int idx = 0; idx < m*p; idx++) begin
                tests++;
                if (cmem_run[idx] != run_id || cmem[idx] !== expc[idx]) begin
                    fails++;
                    $display("FAIL result[%0d] %0dx%0dx%0d got=%0d want=%0d written=%0d",
                             idx, m, n, p, cmem[idx], expc[idx], cmem_run[idx] == run_id);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        bus.mult   = 1'b0;
        bus.m1_dim = '0;
        bus.n1_dim = '0;
        bus.n2_dim = '0;
        bus.stall  = 1'b0;
        #12;
        check_idle_outputs("reset_state");
        @(posedge clk_tb); #1;
        reset = 1'b1;
        @(posedge clk_tb); #1;

        run(2, 2, 2, 0, 1'b0, 1'b0, 0);
        run(3, 2, 1, 0, 1'b0, 1'b1, 0);
        run(2, 2, 2, 1, 1'b0, 1'b0, 0);
        run(1, 1, 1, 0, 1'b0, 1'b0, 0);
        run(0, 3, 3, 0, 1'b0, 1'b0, 0);
        run(2, 2, 129, 0, 1'b0, 1'b0, 0);
        run(3, 0, 2, 0, 1'b0, 1'b0, 0);
        run(200, 1, 1, 0, 1'b0, 1'b0, 0);

        run(4, 4, 4, 0, 1'b0, 1'b0, 5);
        repeat (2) @(posedge clk_tb);
        #1;
        reset = 1'b1;
        @(posedge clk_tb); #1;
        run(4, 4, 4, 0, 1'b0, 1'b0, 0);

        run(2, 3, 2, 0, 1'b1, 1'b0, 0);
        run(3, 1, 2, 0, 1'b0, 1'b0, 0);

        run(128, 1, 2, 2, 1'b0, 1'b0, 0);
        run(1, 128, 1, 2, 1'b0, 1'b0, 0);
        for (int r = 0; r < 8; r++)
            run($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5), 2, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk_tb);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
